alu_arbiter: RTL

Two-port arbiter and sequencer for the shared 32-bit combinational ALU. It accepts operation requests from two requesters, grants them round-robin, and drives the ALU from registered operand and opcode latches. It captures the ALU result and ZERO status and returns them to the winning requester with a one-cycle DONE pulse. It sits between the ALU instance and its clients (for example, the control unit and an address-generation path).

---
 rtl/alu_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a shared combinational ALU.
// Latches the winner's operands, waits one cycle for the ALU, then returns the result with a DONE pulse.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OPRN_WIDTH = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic [DATA_WIDTH-1:0] OP1_0,
    input  logic [DATA_WIDTH-1:0] OP2_0,
    input  logic [OPRN_WIDTH-1:0] OPRN_0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] OP1_1,
    input  logic [DATA_WIDTH-1:0] OP2_1,
    input  logic [OPRN_WIDTH-1:0] OPRN_1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic                  DONE0,
    output logic                  DONE1,
    output logic [DATA_WIDTH-1:0] RES0,
    output logic [DATA_WIDTH-1:0] RES1,
    output logic                  ZERO0,
    output logic                  ZERO1,
    output logic                  ERR0,
    output logic                  ERR1,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] ALU_OP1,
    output logic [DATA_WIDTH-1:0] ALU_OP2,
    output logic [OPRN_WIDTH-1:0] ALU_OPRN,
    input  logic [DATA_WIDTH-1:0] ALU_OUT,
    input  logic                  ALU_ZERO
);

    localparam logic [OPRN_WIDTH-1:0] OPRN_FIRST = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OPRN_LAST  = OPRN_WIDTH'(9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                  prio_q, prio_d;
    logic                  win_q, win_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
    logic [OPRN_WIDTH-1:0] alu_oprn_q, alu_oprn_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  done0_q, done0_d, done1_q, done1_d;
    logic [DATA_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
    logic                  zero0_q, zero0_d, zero1_q, zero1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic                  busy_q, busy_d;

    logic                  any_req_c;
    logic                  win_c;
    logic [OPRN_WIDTH-1:0] oprn_sel_c;
    logic                  legal_c;
    logic [DATA_WIDTH-1:0] cap_res_c;
    logic                  cap_zero_c;

    // Contention goes to the pointer; a lone requester always wins.
    assign any_req_c  = REQ0 | REQ1;
    assign win_c      = (REQ0 & REQ1) ? prio_q : REQ1;
    assign oprn_sel_c = win_c ? OPRN_1 : OPRN_0;
    assign legal_c    = (oprn_sel_c >= OPRN_FIRST) && (oprn_sel_c <= OPRN_LAST);

    // Illegal ops report a forced zero result with ZERO low, ignoring the ALU.
    assign cap_res_c  = illegal_q ? '0 : ALU_OUT;
    assign cap_zero_c = ~illegal_q & ALU_ZERO;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any_req_c) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        prio_d     = prio_q;
        win_d      = win_q;
        illegal_d  = illegal_q;
        alu_op1_d  = alu_op1_q;
        alu_op2_d  = alu_op2_q;
        alu_oprn_d = alu_oprn_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        done0_d    = 1'b0;
        done1_d    = 1'b0;
        res0_d     = res0_q;
        res1_d     = res1_q;
        zero0_d    = zero0_q;
        zero1_d    = zero1_q;
        err0_d     = err0_q;
        err1_d     = err1_q;
        busy_d     = (state_d != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (any_req_c) begin
                    win_d      = win_c;
                    prio_d     = ~win_c;
                    illegal_d  = ~legal_c;
                    alu_op1_d  = win_c ? OP1_1 : OP1_0;
                    alu_op2_d  = win_c ? OP2_1 : OP2_0;
                    alu_oprn_d = legal_c ? oprn_sel_c : '0;
                    ack0_d     = ~win_c;
                    ack1_d     = win_c;
                end
            end
            ST_EXEC: begin
                if (win_q) begin
                    res1_d  = cap_res_c;
                    zero1_d = cap_zero_c;
                    err1_d  = illegal_q;
                    done1_d = 1'b1;
                end else begin
                    res0_d  = cap_res_c;
                    zero0_d = cap_zero_c;
                    err0_d  = illegal_q;
                    done0_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            prio_q     <= 1'b0;
            win_q      <= 1'b0;
            illegal_q  <= 1'b0;
            alu_op1_q  <= '0;
            alu_op2_q  <= '0;
            alu_oprn_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            res0_q     <= '0;
            res1_q     <= '0;
            zero0_q    <= 1'b0;
            zero1_q    <= 1'b0;
            err0_q     <= 1'b0;
            err1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            win_q      <= win_d;
            illegal_q  <= illegal_d;
            alu_op1_q  <= alu_op1_d;
            alu_op2_q  <= alu_op2_d;
            alu_oprn_q <= alu_oprn_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            done0_q    <= done0_d;
            done1_q    <= done1_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            zero0_q    <= zero0_d;
            zero1_q    <= zero1_d;
            err0_q     <= err0_d;
            err1_q     <= err1_d;
            busy_q     <= busy_d;
        end
    end

    assign ACK0     = ack0_q;
    assign ACK1     = ack1_q;
    assign DONE0    = done0_q;
    assign DONE1    = done1_q;
    assign RES0     = res0_q;
    assign RES1     = res1_q;
    assign ZERO0    = zero0_q;
    assign ZERO1    = zero1_q;
    assign ERR0     = err0_q;
    assign ERR1     = err1_q;
    assign BUSY     = busy_q;
    assign ALU_OP1  = alu_op1_q;
    assign ALU_OP2  = alu_op2_q;
    assign ALU_OPRN = alu_oprn_q;

endmodule
